up_timer_tff: RTL and testbench
===============================

Name: up_timer_tff

Overview:
- Loadable up-counting interval timer built from a T-flip-flop ripple-carry chain. It is the counterpart of the team's loadable down counter: it counts up from a start value toward a target instead of down toward zero.
- Generates obstacle-spacing and frame-interval ticks for the game logic.
- Supports one-shot and periodic (auto-reload) modes under a small control FSM.

Parameters:
- BITS, 9, width of the counter, start value and target.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  level-sampled each edge; latches start_val/target and begins counting
- abort  input  1  returns the FSM to IDLE; priority over start
- mode  input  1  0 = one-shot, 1 = periodic auto-reload
- start_val  input  BITS  initial count value
- target  input  BITS  terminal count value
- count  output  BITS  current counter value (true polarity)
- busy  output  1  high while in RUN
- tick  output  1  one-cycle pulse per terminal-count match
- done  output  1  high in DONE (one-shot finished)

Behaviour:
- Clocking and reset: one clock (clk). Reset is asynchronous, active-low (rst_n). All outputs are registered.
- Reset values: state=IDLE, count=0, start_q=0, target_q=0, busy=0, tick=0, done=0. Asserting rst_n low mid-RUN clears everything immediately, without waiting for a clock edge.
- FSM states: IDLE, RUN, DONE.
- Start: in IDLE or DONE, start=1 with abort=0 causes, at the edge:
  - count<=start_val; start_q<=start_val; target_q<=target; state->RUN; busy<=1; done<=0.
- RUN, count!=target_q: count<=count+1, modulo 2^BITS. Wrap-around is legal, so target<start counts through 2^BITS-1 to 0.
- RUN, count==target_q: tick<=1 for exactly one cycle, then:
  - mode=1: count<=start_q; remain in RUN.
  - mode=0: count holds; state->DONE; busy<=0; done<=1.
- mode is sampled every cycle (not latched), so it may be changed mid-run.
- tick is asserted in the cycle after count shows target_q.
- Tick latency: first tick occurs ((target-start_val) mod 2^BITS)+1 edges after the start edge.
- Periodic interval: ((target-start_val) mod 2^BITS)+1 cycles. If start_val==target, tick stays high every cycle after the first match.
- start in RUN (abort=0): restarts the timer. count, start_q and target_q reload; no tick is produced that edge, even if count==target_q.
- abort=1 in any state: state->IDLE; busy<=0; tick<=0; done<=0; count holds its current value. abort with start in the same cycle: abort wins.
- DONE: done and count hold until start or abort.
- IDLE: count holds; tick=0.
- Counter implementation:
  - T-flip-flop chain with T[0]=en and T[i]=T[i-1]&q[i-1].
  - A synchronous load overrides toggling.
  - No adders or comparators other than a BITS-wide equality check.

Decomposition:
- Shared package (timer_pkg): state encodings ST_IDLE=2'b00, ST_RUN=2'b01, ST_DONE=2'b10; default width constant TIMER_BITS=9.
- Sub-module up_counter_tff:
  - BITS-wide loadable up counter from per-bit T flip-flops.
  - Ports: clk, rst_n, en, load_en, data, q.
  - Load has priority over en.
- The top level holds the FSM, start_q/target_q registers, the match compare and the tick/done registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release -> count=0, busy=0, tick=0, done=0; IDLE with no start -> count stays 0.
- One-shot: mode=0, start_val=5, target=8, 1-cycle start pulse -> count=5,6,7,8 on edges 1-4; tick=1 only after edge 5; done=1 and busy=0 from edge 5; count holds 8.
- Periodic: mode=1, start_val=0, target=3 -> count sequence 0,1,2,3,0,1,…; tick every 4th cycle; busy stays 1.
- Wrap-around: start_val=510, target=1, mode=0 -> count=510,511,0,1; tick after edge 5; done=1.
- Degenerate: start_val=target=7, mode=1 -> count stays 7; tick=1 on every cycle from edge 2 onward.
- Abort and reset:
  - abort and start together at count=2 during a 0→3 periodic run -> IDLE, busy=0, no tick, count holds 2.
  - Separate run: asynchronous rst_n low mid-run -> outputs clear before the next clock edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared definitions for the up-counting interval timer: control FSM
// state encodings and the default counter width.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int TIMER_BITS = 9;

endpackage : timer_pkg

// File: rtl/up_counter_tff.sv
// Loadable up counter built from per-bit T flip-flops with a ripple toggle
// chain: bit i toggles when enabled and every lower bit is 1. Load wins
// over counting.
module up_counter_tff #(
  parameter int BITS = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            load_en,
  input  logic [BITS-1:0] data,
  output logic [BITS-1:0] q
);

  logic [BITS-1:0] t;

  assign t[0] = en;

  genvar gi;
  generate
    for (gi = 1; gi < BITS; gi++) begin : g_toggle_chain
      assign t[gi] = t[gi-1] & q[gi-1];
    end

    for (gi = 0; gi < BITS; gi++) begin : g_tff
      // One T flip-flop per bit; a synchronous load overrides the toggle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q[gi] <= 1'b0;
        end else if (load_en) begin
          q[gi] <= data[gi];
        end else if (t[gi]) begin
          q[gi] <= ~q[gi];
        end
      end
    end
  endgenerate

endmodule : up_counter_tff

// File: rtl/up_timer_tff.sv
// Up-counting interval timer: counts from a latched start value to a
// latched target, pulses tick on each match, and either stops (one-shot)
// or reloads the start value (periodic). mode is sampled live every cycle.
module up_timer_tff
  import timer_pkg::*;
#(
  parameter int BITS = TIMER_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            mode,
  input  logic [BITS-1:0] start_val,
  input  logic [BITS-1:0] target,
  output logic [BITS-1:0] count,
  output logic            busy,
  output logic            tick,
  output logic            done
);

  state_t          state_reg, state_next;
  logic [BITS-1:0] start_q, start_q_next;
  logic [BITS-1:0] target_q, target_q_next;
  logic            busy_reg, busy_next;
  logic            tick_reg, tick_next;
  logic            done_reg, done_next;
  logic            cnt_en, cnt_load;
  logic [BITS-1:0] cnt_data;
  logic            match;

  up_counter_tff #(.BITS(BITS)) u_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (cnt_en),
    .load_en (cnt_load),
    .data    (cnt_data),
    .q       (count)
  );

  // The only comparator in the design: terminal-count equality.
  assign match = (count == target_q);

  // State and control registers; cleared immediately by rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      start_q   <= '0;
      target_q  <= '0;
      busy_reg  <= 1'b0;
      tick_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      start_q   <= start_q_next;
      target_q  <= target_q_next;
      busy_reg  <= busy_next;
      tick_reg  <= tick_next;
      done_reg  <= done_next;
    end
  end

  // Next state, counter control and output register inputs.
  // abort beats start; start (re)loads from any state, including RUN.
  always_comb begin
    state_next    = state_reg;
    start_q_next  = start_q;
    target_q_next = target_q;
    busy_next     = busy_reg;
    tick_next     = 1'b0;
    done_next     = done_reg;
    cnt_en        = 1'b0;
    cnt_load      = 1'b0;
    cnt_data      = start_val;

    if (abort) begin
      state_next = ST_IDLE;
      busy_next  = 1'b0;
      done_next  = 1'b0;
    end else if (start) begin
      cnt_load      = 1'b1;
      cnt_data      = start_val;
      start_q_next  = start_val;
      target_q_next = target;
      state_next    = ST_RUN;
      busy_next     = 1'b1;
      done_next     = 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (match) begin
            tick_next = 1'b1;
            if (mode) begin
              cnt_load = 1'b1;
              cnt_data = start_q;
            end else begin
              state_next = ST_DONE;
              busy_next  = 1'b0;
              done_next  = 1'b1;
            end
          end else begin
            cnt_en = 1'b1;
          end
        end
        default: begin
          // IDLE and DONE hold count and flags; tick stays low.
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign tick = tick_reg;
  assign done = done_reg;

endmodule : up_timer_tff

// File: tb/tb_up_timer_tff.sv
// Scoreboard bench for up_timer_tff: the stimulus process pushes the
// expected {count,busy,tick,done} after each edge; an independent monitor
// pops and compares on the falling edge.
module tb_up_timer_tff;

  localparam int BITS = 9;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            abort;
  logic            mode;
  logic [BITS-1:0] start_val;
  logic [BITS-1:0] target;
  logic [BITS-1:0] count;
  logic            busy;
  logic            tick;
  logic            done;

  typedef struct {
    logic [BITS-1:0] cnt;
    logic            busy;
    logic            tick;
    logic            done;
    string           name;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  up_timer_tff #(.BITS(BITS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .mode      (mode),
    .start_val (start_val),
    .target    (target),
    .count     (count),
    .busy      (busy),
    .tick      (tick),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input int c, input logic b, input logic t, input logic d);
    exp_t e;
    e.cnt  = c[BITS-1:0];
    e.busy = b;
    e.tick = t;
    e.done = d;
    e.name = phase;
    exp_q.push_back(e);
  endtask

  // Advance one rising edge, then record what the outputs must show.
  task automatic cyc(input int c, input logic b, input logic t, input logic d);
    @(posedge clk);
    #1;
    push_exp(c, b, t, d);
  endtask

  // Monitor: compare every pending expectation on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_checks++;
        if (count !== e.cnt || busy !== e.busy || tick !== e.tick || done !== e.done) begin
          n_fail++;
          $display("FAIL %s: got count=%0d busy=%b tick=%b done=%b, expected count=%0d busy=%b tick=%b done=%b",
                   e.name, count, busy, tick, done, e.cnt, e.busy, e.tick, e.done);
        end else begin
          $display("ok   %s: count=%0d busy=%b tick=%b done=%b", e.name, count, busy, tick, done);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    start_val = '0; target = '0;

    // Reset held for 3 cycles, then idle with no start.
    phase = "reset";
    repeat (3) cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    phase = "idle";
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // One-shot 5 -> 8.
    phase = "oneshot";
    mode = 1'b0; start_val = 9'd5; target = 9'd8; start = 1'b1;
    cyc(5, 1, 0, 0);
    start = 1'b0;
    cyc(6, 1, 0, 0);
    cyc(7, 1, 0, 0);
    cyc(8, 1, 0, 0);
    cyc(8, 0, 1, 1);
    cyc(8, 0, 0, 1);
    cyc(8, 0, 0, 1);

    // Periodic 0 -> 3 from DONE, then abort+start together at count=2.
    phase = "periodic";
    mode = 1'b1; start_val = 9'd0; target = 9'd3; start = 1'b1;
    cyc(0, 1, 0, 0);
    start = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(2, 1, 0, 0);
    cyc(3, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(2, 1, 0, 0);
    cyc(3, 1, 0, 0);
    cyc(0, 1, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(2, 1, 0, 0);
    phase = "abort_wins";
    abort = 1'b1; start = 1'b1;
    cyc(2, 0, 0, 0);
    abort = 1'b0; start = 1'b0;
    cyc(2, 0, 0, 0);

    // Wrap-around one-shot 510 -> 1.
    phase = "wrap";
    mode = 1'b0; start_val = 9'd510; target = 9'd1; start = 1'b1;
    cyc(510, 1, 0, 0);
    start = 1'b0;
    cyc(511, 1, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 0, 1);

    // Degenerate periodic 7 == 7: tick every cycle after the first match.
    phase = "degenerate";
    mode = 1'b1; start_val = 9'd7; target = 9'd7; start = 1'b1;
    cyc(7, 1, 0, 0);
    start = 1'b0;
    cyc(7, 1, 1, 0);
    cyc(7, 1, 1, 0);
    cyc(7, 1, 1, 0);
    // Restart while running at a match: no tick on the restart edge.
    phase = "restart_run";
    start = 1'b1;
    cyc(7, 1, 0, 0);
    start = 1'b0;
    cyc(7, 1, 1, 0);
    // Switch to one-shot mid-run: next match finishes.
    phase = "mode_switch";
    mode = 1'b0;
    cyc(7, 0, 1, 1);
    cyc(7, 0, 0, 1);

    // Asynchronous reset mid-run clears outputs before the next edge.
    phase = "async_rst";
    mode = 1'b1; start_val = 9'd0; target = 9'd3; start = 1'b1;
    cyc(0, 1, 0, 0);
    start = 1'b0;
    cyc(1, 1, 0, 0);
    cyc(2, 1, 0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    push_exp(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    phase = "after_rst";
    cyc(0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_up_timer_tff
